// File: rtl/fp_cus_pkg.sv
// Shared types and constants for the IEEE-754 single to custom multiplier word converter.
package fp_cus_pkg;

  localparam int EXP_W   = 7;
  localparam int MANT_W  = 24;
  localparam int NUM_OPS = 2;

  localparam logic signed [8:0] IEEE_BIAS = 9'sd127;
  localparam logic signed [8:0] EXP_MIN   = -9'sd64;
  localparam logic signed [8:0] EXP_MAX   = 9'sd63;

  localparam int FLG_UNF = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_NAN = 2;

  localparam logic [30:0] CUS_SAT_MAG = {7'h3F, 24'hFFFFFF};

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;   // signed, ieee_exp - 127
    logic [22:0] frac;
    cls_e        cls;
  } dec_t;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  flags;
  } enc_t;

  function automatic enc_t encode(input dec_t d);
    enc_t r;
    r.word  = '0;
    r.flags = '0;
    unique case (d.cls)
      CLS_NORM: begin
        if ($signed(d.exp) > EXP_MAX) begin
          r.word           = {d.sign, CUS_SAT_MAG};
          r.flags[FLG_OVF] = 1'b1;
        end else if ($signed(d.exp) < EXP_MIN) begin
          r.flags[FLG_UNF] = 1'b1;
        end else begin
          r.word = {d.sign, d.exp[EXP_W-1:0], 1'b1, d.frac};
        end
      end
      CLS_INF: begin
        r.word           = {d.sign, CUS_SAT_MAG};
        r.flags[FLG_OVF] = 1'b1;
      end
      CLS_NAN: begin
        r.word           = {1'b0, CUS_SAT_MAG};
        r.flags[FLG_NAN] = 1'b1;
      end
      default: ;  // zero/denormal: word and flags stay 0, sign dropped
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_ieee_to_cus_if.sv
// Operand-pair stream into the converter and converted-pair stream out to the multiplier.
interface fp_ieee_to_cus_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ieee_a;
  logic [31:0] ieee_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [2:0]  flags_a;
  logic [2:0]  flags_b;

  modport master (
    output in_valid, ieee_a, ieee_b, out_ready,
    input  in_ready, out_valid, dataa, datab, flags_a, flags_b
  );

  modport slave (
    input  in_valid, ieee_a, ieee_b, out_ready,
    output in_ready, out_valid, dataa, datab, flags_a, flags_b
  );
endinterface

// File: rtl/fp_ieee_unpack.sv
// Combinational decode of one IEEE-754 single into sign, unbiased exponent, fraction, class.
module fp_ieee_unpack
  import fp_cus_pkg::*;
(
  input  logic [31:0] ieee_i,
  output dec_t        dec_o
);

  always_comb begin
    dec_o.sign = ieee_i[31];
    dec_o.exp  = $signed({1'b0, ieee_i[30:23]}) - IEEE_BIAS;
    dec_o.frac = ieee_i[22:0];
    if (ieee_i[30:23] == 8'h00)      dec_o.cls = CLS_ZERO;
    else if (ieee_i[30:23] == 8'hFF) dec_o.cls = (ieee_i[22:0] != '0) ? CLS_NAN : CLS_INF;
    else                             dec_o.cls = CLS_NORM;
  end

endmodule

// File: rtl/fp_ieee_to_cus.sv
// Two-stage IEEE single -> custom multiplier word converter with valid/ready flow control.
// Optional FP_CONV_SAT_CNT_EN adds a saturating count of flagged operands on output transfer.
module fp_ieee_to_cus
  import fp_cus_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  fp_ieee_to_cus_if.slave   bus
`ifdef FP_CONV_SAT_CNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  logic [NUM_OPS-1:0][31:0] ieee;
  dec_t dec_d    [NUM_OPS];
  dec_t s1_dec_q [NUM_OPS];
  enc_t enc_d    [NUM_OPS];
  enc_t s2_enc_q [NUM_OPS];
  logic s1_valid_q, s2_valid_q;
  logic s1_advance, in_ready;

  assign ieee = {bus.ieee_b, bus.ieee_a};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fp_ieee_unpack u_unpack (.ieee_i(ieee[i]), .dec_o(dec_d[i]));
  end

  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) enc_d[i] = encode(s1_dec_q[i]);
  end

  assign s1_advance = !s2_valid_q || bus.out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) begin
        s1_dec_q[i] <= '0;
        s2_enc_q[i] <= '0;
      end
    end else begin
      if (in_ready) s1_valid_q <= bus.in_valid;
      if (bus.in_valid && in_ready) s1_dec_q <= dec_d;
      if (s1_advance) s2_valid_q <= s1_valid_q;
      // Stage 2 holds its word while stalled; only a real advance of a valid pair reloads it.
      if (s1_advance && s1_valid_q) s2_enc_q <= enc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.dataa     = s2_enc_q[0].word;
  assign bus.datab     = s2_enc_q[1].word;
  assign bus.flags_a   = s2_enc_q[0].flags;
  assign bus.flags_b   = s2_enc_q[1].flags;

`ifdef FP_CONV_SAT_CNT_EN
  logic [15:0] sat_q, sat_d;
  logic [16:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_q} + {15'd0, |s2_enc_q[0].flags} + {15'd0, |s2_enc_q[1].flags};
    sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset)                              sat_q <= '0;
    else if (s2_valid_q && bus.out_ready)   sat_q <= sat_d;
  end

  assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_fp_ieee_to_cus.sv
// Self-checking bench for fp_ieee_to_cus: directed table, stall/reset sequences, random vs model.
module tb_fp_ieee_to_cus;

  typedef struct {
    logic [31:0] wa, wb;
    logic [2:0]  fa, fb;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    exp_t        e;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fp_ieee_to_cus_if bus();
`ifdef FP_CONV_SAT_CNT_EN
  logic [15:0] sat_count;
  int sat_model = 0;
`endif

  fp_ieee_to_cus dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef FP_CONV_SAT_CNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];
  exp_t mon_e;
  logic        prev_stall = 1'b0;
  logic [69:0] prev_out;
  bit   rnd_done;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endfunction

  // Reference: custom word from the numeric value's unbiased exponent and range rules.
  function automatic logic [34:0] model(input logic [31:0] x);
    int e  = int'(x[30:23]);
    int ue = e - 127;
    if (e == 0)   return 35'd0;
    if (e == 255) return (x[22:0] != 0) ? {32'h3FFF_FFFF, 3'b100} : {x[31], 31'h3FFF_FFFF, 3'b010};
    if (ue > 63)  return {x[31], 31'h3FFF_FFFF, 3'b010};
    if (ue < -64) return {32'd0, 3'b001};
    return {x[31], 7'(ue), 1'b1, x[22:0], 3'b000};
  endfunction

  function automatic exp_t model_pair(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [34:0] ma, mb;
    ma = model(a); mb = model(b);
    r.wa = ma[34:3]; r.fa = ma[2:0];
    r.wb = mb[34:3]; r.fb = mb[2:0];
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f = 23'($urandom);
    case ($urandom_range(0, 5))
      0: e = 8'($urandom);
      1: e = 8'($urandom_range(61, 64));
      2: e = 8'($urandom_range(189, 192));
      3: e = 8'h00;
      4: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
      default: e = 8'($urandom_range(100, 160));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard: compare every output transfer, and hold-stability while stalled.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got dataa %h with no pending pair", bus.dataa);
        end else begin
          mon_e = q.pop_front();
          check("out_a", {29'd0, bus.dataa, bus.flags_a}, {29'd0, mon_e.wa, mon_e.fa});
          check("out_b", {29'd0, bus.datab, bus.flags_b}, {29'd0, mon_e.wb, mon_e.fb});
`ifdef FP_CONV_SAT_CNT_EN
          sat_model += int'(|mon_e.fa) + int'(|mon_e.fb);
`endif
        end
      end
      if (prev_stall)
        check("stall_hold", {bus.out_valid, bus.dataa, bus.datab, bus.flags_a, bus.flags_b}, prev_out);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_valid, bus.dataa, bus.datab, bus.flags_a, bus.flags_b};
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.ieee_a = a; bus.ieee_b = b;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (bus.in_ready) begin q.push_back(e); ok = 1; end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin checks++; $display("FAIL accept_timeout: in_ready stuck at 0, wanted 1"); end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 100 && (q.size() != 0 || bus.out_valid); n++) @(posedge clock);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_latency(input string tag);
    @(negedge clock); check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    @(negedge clock); check({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
  endtask

  vec_t tbl[7];
  logic [31:0] ra, rb;

  initial begin
    tbl[0] = '{32'h40EC511A, 32'h3F800000, '{32'h02EC511A, 32'h00800000, 3'b000, 3'b000}};
    tbl[1] = '{32'hC0000000, 32'h5F800000, '{32'h81800000, 32'h3FFFFFFF, 3'b000, 3'b010}};
    tbl[2] = '{32'h00000001, 32'h1F000000, '{32'h00000000, 32'h00000000, 3'b000, 3'b001}};
    tbl[3] = '{32'hFF800000, 32'h7FC00000, '{32'hBFFFFFFF, 32'h3FFFFFFF, 3'b010, 3'b100}};
    tbl[4] = '{32'hFFC00001, 32'h80000000, '{32'h3FFFFFFF, 32'h00000000, 3'b100, 3'b000}};
    tbl[5] = '{32'h5F000000, 32'h9F800000, '{32'h3F800000, 32'hC0800000, 3'b000, 3'b000}};
    tbl[6] = '{32'h7F7FFFFF, 32'h00800000, '{32'h3FFFFFFF, 32'h00000000, 3'b010, 3'b001}};

    bus.in_valid = 1'b0; bus.ieee_a = '0; bus.ieee_b = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_data",      {bus.dataa, bus.datab}, 64'd0);
    check("rst_flags",     64'({bus.flags_a, bus.flags_b}), 64'd0);
`ifdef FP_CONV_SAT_CNT_EN
    check("rst_sat_count", 64'(sat_count), 64'd0);
`endif
    @(posedge clock); #1;

    // Latency on an empty pipeline, then the directed table back-to-back.
    send(tbl[0].a, tbl[0].b, tbl[0].e);
    check_latency("first");
    @(posedge clock); #1;
    for (int i = 1; i < 7; i++) send(tbl[i].a, tbl[i].b, tbl[i].e);
    drain();

    // Backpressure: in_ready drops only once both stages hold a pair.
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, model_pair(32'h3F800000, 32'h40000000));
    send(32'h40400000, 32'h40800000, model_pair(32'h40400000, 32'h40800000));
    @(negedge clock);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid",    64'(bus.out_valid), 64'd1);
    fork
      begin
        send(32'h40A00000, 32'hC0C00000, model_pair(32'h40A00000, 32'hC0C00000));
        send(32'h7F800000, 32'h1F000000, model_pair(32'h7F800000, 32'h1F000000));
        send(32'h3FC00000, 32'h00000000, model_pair(32'h3FC00000, 32'h00000000));
      end
      begin
        repeat (3) @(posedge clock);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages occupied discards everything.
    bus.out_ready = 1'b0;
    send(32'h40EC511A, 32'h7F800000, model_pair(32'h40EC511A, 32'h7F800000));
    send(32'hFF800000, 32'h3F800000, model_pair(32'hFF800000, 32'h3F800000));
    reset = 1'b1;
    q.delete();
    @(posedge clock); #1 reset = 1'b0;
`ifdef FP_CONV_SAT_CNT_EN
    sat_model = 0;
`endif
    @(negedge clock);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_dataa",     64'(bus.dataa),     64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef FP_CONV_SAT_CNT_EN
    check("mid_rst_sat_count", 64'(sat_count), 64'd0);
`endif
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    send(32'h40EC511A, 32'h3F800000, model_pair(32'h40EC511A, 32'h3F800000));
    check_latency("post_rst");
    drain();

`ifdef FP_CONV_SAT_CNT_EN
    reset = 1'b1; q.delete();
    @(posedge clock); #1 reset = 1'b0;
    sat_model = 0;
    send(32'h7F800000, 32'h3F800000, model_pair(32'h7F800000, 32'h3F800000));
    send(32'h3F800000, 32'h1F000000, model_pair(32'h3F800000, 32'h1F000000));
    send(32'h7FC00000, 32'h00000000, model_pair(32'h7FC00000, 32'h00000000));
    send(32'hFF800000, 32'h5F800000, model_pair(32'hFF800000, 32'h5F800000));
    drain();
    @(negedge clock);
    check("sat_count_five", 64'(sat_count), 64'd5);
`endif

    // Random operands with random output stalls.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          ra = rand_op(); rb = rand_op();
          send(ra, rb, model_pair(ra, rb));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
`ifdef FP_CONV_SAT_CNT_EN
    @(negedge clock);
    check("sat_count_model", 64'(sat_count), 64'(sat_model));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/fp_ieee_to_cus.md
# fp_ieee_to_cus

Two-stage pipelined converter that turns a pair of IEEE-754 single-precision operands into the custom multiplier word format and presents them as `dataa`/`datab` to `myfpmult`. It sits directly upstream of the multiplier. It uses a valid/ready handshake so the multiplier side can stall the stream. Each operand also gets range/exception flags that travel alongside it.

## Interface
- `EXP_W`, 7: custom exponent width, two's complement, unbiased.
- `MANT_W`, 24: custom mantissa width, hidden bit explicit.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  IEEE operand pair presented.
- `in_ready`  out  1  converter accepts the pair this cycle.
- `ieee_a`, `ieee_b`  in  32 each  IEEE-754 single operands.
- `out_valid`  out  1  converted pair available.
- `out_ready`  in  1  multiplier side consumes the pair.
- `dataa`, `datab`  out  32 each  custom words {sign, exp[6:0], mant[23:0]}.
- `flags_a`, `flags_b`  out  3 each  {nan, ovf, unf}.
- `sat_count`  out  16  range-event count (only with `FP_CONV_SAT_CNT_EN`).

## Operation
- Custom word layout: bit 31 is the sign. Bits 30:24 are the exponent `E = ieee_exp − 127`, 7-bit two's complement, legal range −64..63. Bits 23:0 are the mantissa `{1'b1, frac[22:0]}`.
- Stage 1 (decode): registers the sign, the 9-bit signed `ieee_exp − 127`, the fraction, and the operand class. Classes are zero/denormal, normal, inf and NaN.
- Stage 2 (encode) forms the output word for each class:
  - Zero or denormal: word = 0x00000000, flags = 0. The sign is dropped.
  - Normal with E in range: exact word, flags = 0.
  - Normal with E > 63: {sign, 7'h3F, 24'hFFFFFF}, `ovf` = 1.
  - Normal with E < −64: 0x00000000, `unf` = 1.
  - Inf: same saturated word as E > 63, `ovf` = 1.
  - NaN: saturated word with sign 0, `nan` = 1.
- There is no rounding. Fraction bits map 1:1.
- Operands a and b are handled independently but always move as one pair.
- Handshake:
  - A transfer occurs on any cycle where valid and ready are both 1 at the rising edge.
  - `in_ready = !s1_valid || s1_advance`.
  - `s1_advance = !s2_valid || out_ready`.
  - Outputs stay stable while `out_valid && !out_ready`.

## Timing
- Latency: 2 cycles from accept to `out_valid`, when there is no stall.
- Throughput: 1 pair per cycle.
- Capacity: 2 pairs in flight. With `out_ready` held low, `in_ready` drops only after both stages are full.
- Reset values: `out_valid`=0, `in_ready`=1 (combinational, from empty stages), `dataa`=`datab`=0, flags=0, `sat_count`=0.
- Reset while the pipeline is occupied: all in-flight pairs are discarded. The cycle after reset deasserts shows an empty pipeline.
- Simultaneous accept and consume with both stages full: stage 2 loads from stage 1 and stage 1 loads the new pair. Nothing is lost or duplicated.
- `in_valid` low with `out_ready` high: the pipeline drains one stage per cycle.
- Data values in stages whose valid is low are don't-care. Flags are only meaningful while `out_valid`=1.

## Configuration
- `FP_CONV_SAT_CNT_EN` defined: adds the `sat_count` port.
  - Counts +1 for each operand with any flag set, counted on output transfer. A pair with both operands flagged adds +2.
  - Saturates at 0xFFFF. Cleared by `reset`.
- Not defined: no port, no counter logic. All other behaviour is identical.

## Structure
- Shared package `fp_cus_pkg` holds:
  - field widths `EXP_W`, `MANT_W`, `IEEE_BIAS`=127;
  - `EXP_MIN`=−64, `EXP_MAX`=63;
  - class enum {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN};
  - flag bit indices;
  - constant `CUS_SAT_MAG` = {7'h3F, 24'hFFFFFF}.
- Sub-module `fp_ieee_unpack`: combinational per-operand decode (sign, unbiased exponent, fraction, class). It is instantiated twice in stage 1.

## Test plan
- Single normal operand: `ieee_a`=0x40EC511A (7.3849), `ieee_b`=0x3F800000 (1.0) → 2 cycles later `dataa`=0x02EC511A, `datab`=0x00800000, flags 0.
- Sign, overflow and zero: `ieee_a`=0xC0000000 → 0x81800000. `ieee_b`=0x5F800000 (E=64) → 0x3FFFFFFF, `flags_b`=3'b010. Then a=0x00000001 (denormal) → 0x00000000, flags 0.
- Underflow, Inf and NaN:
  - 0x1F000000 (E=−65) → 0x00000000, `unf`.
  - 0xFF800000 → 0xBFFFFFFF, `ovf`.
  - 0x7FC00000 → 0x3FFFFFFF, `nan`.
- Backpressure: stream 5 pairs with `out_ready` low for cycles 2–5 → `in_ready` falls after the 2nd accept. All 5 outputs appear in order, none lost or duplicated. Outputs are stable while stalled.
- Reset mid-stream: assert `reset` with both stages valid → next cycle `out_valid`=0, `dataa`=0, `sat_count`=0. The first pair after reset emerges 2 cycles after its accept.
- With `FP_CONV_SAT_CNT_EN`: 3 pairs with one flagged operand each, plus one pair with both flagged → `sat_count`=5 after the final output transfer.
